// File: rtl/fb_rect_fill_if.sv
// rtl/fb_rect_fill_if.sv - command and BRAM port A bundle for the rectangle filler.
interface fb_rect_fill_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_y0;
  logic [9:0]  cmd_w;
  logic [9:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        busy;
  logic        done;
  logic [18:0] bram_addra;
  logic        bram_clka;
  logic [31:0] bram_dina;
  logic        bram_ena;
  logic        bram_rsta;
  logic [3:0]  bram_wea;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, busy, done, bram_addra, bram_clka, bram_dina,
    input  bram_ena, bram_rsta, bram_wea
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    output cmd_ready, busy, done, bram_addra, bram_clka, bram_dina,
    output bram_ena, bram_rsta, bram_wea
  );
endinterface

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - clipped solid-rectangle filler for the 8bpp framebuffer.
// One registered port A write per cycle; word writes on aligned 4-pixel spans.
module fb_rect_fill #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic          clk,
  input  logic          resetn,
  fb_rect_fill_if.slave bus
);
  localparam logic [10:0] H_END  = 11'(H_RES);
  localparam logic [10:0] V_END  = 11'(V_RES);
  localparam logic [18:0] STRIDE = 19'(H_RES);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic [10:0] x_end_q, x_end_d, y_end_q, y_end_d, x_q, x_d, y_q, y_d;
  logic [18:0] row_base_q, row_base_d;
  logic        last_q, last_d;
  logic        ena_q, ena_d;
  logic [3:0]  wea_q, wea_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] dina_q, dina_d;

  logic [10:0] sum_x, sum_y, x_end_c, y_end_c;
  logic [10:0] cur_x, cur_y, cur_xend, cur_yend, span, nx;
  logic [18:0] y0_base, cur_base;
  logic        empty_c, setup, word, issue;

  // SETUP issues the first write itself, so it reads the latched fields directly.
  always_comb begin
    sum_x    = {1'b0, x0_q} + {1'b0, w_q};
    sum_y    = {1'b0, y0_q} + {1'b0, h_q};
    x_end_c  = (sum_x > H_END) ? H_END : sum_x;
    y_end_c  = (sum_y > V_END) ? V_END : sum_y;
    empty_c  = ({1'b0, x0_q} >= H_END) || ({1'b0, y0_q} >= V_END) ||
               (w_q == 10'd0) || (h_q == 10'd0);
    y0_base  = ({9'd0, y0_q} << 9) + ({9'd0, y0_q} << 7);
    setup    = (state_q == S_SETUP);
    cur_x    = setup ? {1'b0, x0_q} : x_q;
    cur_y    = setup ? {1'b0, y0_q} : y_q;
    cur_xend = setup ? x_end_c : x_end_q;
    cur_yend = setup ? y_end_c : y_end_q;
    cur_base = setup ? y0_base : row_base_q;
    span     = cur_xend - cur_x;
    word     = (cur_x[1:0] == 2'b00) && (span >= 11'd4);
    nx       = cur_x + (word ? 11'd4 : 11'd1);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    last_d     = last_q;
    ena_d      = 1'b0;
    wea_d      = 4'h0;
    addr_d     = addr_q;
    dina_d     = dina_q;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          x0_d    = bus.cmd_x0;
          y0_d    = bus.cmd_y0;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x_end_d = x_end_c;
        y_end_d = y_end_c;
        if (empty_c) begin
          state_d = S_DONE;
        end else begin
          issue   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // last_q marks that the write now on the port finished the rectangle.
        if (last_q) state_d = S_DONE;
        else        issue   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      ena_d  = 1'b1;
      wea_d  = word ? 4'hF : (4'b0001 << cur_x[1:0]);
      addr_d = cur_base + {8'd0, cur_x};
      dina_d = {4{color_q}};
      if (nx == cur_xend) begin
        x_d        = {1'b0, x0_q};
        y_d        = cur_y + 11'd1;
        row_base_d = cur_base + STRIDE;
        last_d     = ((cur_y + 11'd1) == cur_yend);
      end else begin
        x_d        = nx;
        y_d        = cur_y;
        row_base_d = cur_base;
        last_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= '0;
      addr_q     <= '0;
      dina_q     <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      last_q     <= last_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      dina_q     <= dina_d;
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.bram_clka  = clk;
  assign bus.bram_rsta  = 1'b0;
  assign bus.bram_ena   = ena_q;
  assign bus.bram_wea   = wea_q;
  assign bus.bram_addra = addr_q;
  assign bus.bram_dina  = dina_q;
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed bench for fb_rect_fill.
// A negedge monitor logs every port A write and done pulse with its time.
module tb_fb_rect_fill;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fb_rect_fill_if bus();
  fb_rect_fill #(.H_RES(640), .V_RES(480)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  time         wr_t[$];
  logic [18:0] wr_a[$];
  logic [3:0]  wr_w[$];
  logic [31:0] wr_d[$];
  int          done_cnt = 0;
  time         done_t = 0;

  always @(negedge clk) begin
    if (bus.bram_ena) begin
      wr_t.push_back($time);
      wr_a.push_back(bus.bram_addra);
      wr_w.push_back(bus.bram_wea);
      wr_d.push_back(bus.bram_dina);
    end
    if (bus.done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  task automatic clear_log;
    wr_t.delete(); wr_a.delete(); wr_w.delete(); wr_d.delete();
  endtask

  task automatic drive_cmd(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
    bus.cmd_x0 = 10'(x0); bus.cmd_y0 = 10'(y0);
    bus.cmd_w = 10'(w); bus.cmd_h = 10'(h);
    bus.cmd_color = c; bus.cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input bit hold, output time acc);
    int n = 0;
    acc = 0;
    while (!bus.cmd_ready && n < 3000) begin
      @(negedge clk); n++;
    end
    if (!bus.cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cmd_ready stayed %b, required 1", bus.cmd_ready);
    end else begin
      @(posedge clk);
      acc = $time;
    end
    if (!hold) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    if (done_cnt == start) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, start + 1);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_y0 = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;
    @(negedge clk); @(negedge clk);
    vectors++; if (bus.bram_ena !== 1'b0) begin miscompares++; $display("FAIL rst_ena: got %b required 0", bus.bram_ena); end
    vectors++; if (bus.bram_wea !== 4'h0) begin miscompares++; $display("FAIL rst_wea: got %h required 0", bus.bram_wea); end
    vectors++; if (bus.bram_addra !== 19'd0) begin miscompares++; $display("FAIL rst_addr: got %0d required 0", bus.bram_addra); end
    vectors++; if (bus.bram_dina !== 32'd0) begin miscompares++; $display("FAIL rst_dina: got %h required 0", bus.bram_dina); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b required 0", bus.done); end
    vectors++; if (bus.bram_rsta !== 1'b0) begin miscompares++; $display("FAIL rst_rsta: got %b required 0", bus.bram_rsta); end
    resetn = 1'b1;
    @(negedge clk);
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b required 1", bus.cmd_ready); end
    vectors++; if (bus.bram_clka !== clk) begin miscompares++; $display("FAIL clka: got %b required %b", bus.bram_clka, clk); end
  endtask

  task automatic test_word_fill;
    time acc; int d0;
    int ea[4];
    ea = '{0, 4, 640, 644};
    clear_log(); d0 = done_cnt;
    @(negedge clk); drive_cmd(0, 0, 8, 2, 8'hE0);
    wait_accept(1'b0, acc);
    wait_done(d0);
    vectors++; if (wr_a.size() != 4) begin miscompares++; $display("FAIL t1_count: got %0d required 4", wr_a.size()); end
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      vectors++; if (wr_a[i] !== 19'(ea[i])) begin miscompares++; $display("FAIL t1_addr[%0d]: got %0d required %0d", i, wr_a[i], ea[i]); end
      vectors++; if (wr_w[i] !== 4'hF) begin miscompares++; $display("FAIL t1_wea[%0d]: got %b required 1111", i, wr_w[i]); end
      vectors++; if (wr_d[i] !== 32'hE0E0E0E0) begin miscompares++; $display("FAIL t1_dina[%0d]: got %h required e0e0e0e0", i, wr_d[i]); end
      vectors++; if (wr_t[i] != acc + 15 + 10 * i) begin miscompares++; $display("FAIL t1_time[%0d]: got %0t required %0t", i, wr_t[i], acc + 15 + 10 * i); end
    end
    vectors++; if (done_t != acc + 55) begin miscompares++; $display("FAIL t1_done_time: got %0t required %0t", done_t, acc + 55); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL t1_after_done: busy %b ready %b required 0 1", bus.busy, bus.cmd_ready); end
  endtask

  task automatic test_partial_row;
    time acc; int d0;
    int ea[3]; logic [3:0] ew[3];
    ea = '{643, 644, 648}; ew = '{4'b1000, 4'b1111, 4'b0001};
    clear_log(); d0 = done_cnt;
    @(negedge clk); drive_cmd(3, 1, 6, 1, 8'h1C);
    wait_accept(1'b0, acc);
    wait_done(d0);
    vectors++; if (wr_a.size() != 3) begin miscompares++; $display("FAIL t2_count: got %0d required 3", wr_a.size()); end
    for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
      vectors++; if (wr_a[i] !== 19'(ea[i])) begin miscompares++; $display("FAIL t2_addr[%0d]: got %0d required %0d", i, wr_a[i], ea[i]); end
      vectors++; if (wr_w[i] !== ew[i]) begin miscompares++; $display("FAIL t2_wea[%0d]: got %b required %b", i, wr_w[i], ew[i]); end
      vectors++; if (wr_d[i] !== 32'h1C1C1C1C) begin miscompares++; $display("FAIL t2_dina[%0d]: got %h required 1c1c1c1c", i, wr_d[i]); end
    end
  endtask

  task automatic test_clip;
    time acc; int d0;
    int ea[2]; logic [3:0] ew[2];
    ea = '{307198, 307199}; ew = '{4'b0100, 4'b1000};
    clear_log(); d0 = done_cnt;
    @(negedge clk); drive_cmd(638, 479, 10, 5, 8'h03);
    wait_accept(1'b0, acc);
    wait_done(d0);
    vectors++; if (wr_a.size() != 2) begin miscompares++; $display("FAIL t3_count: got %0d required 2", wr_a.size()); end
    for (int i = 0; i < 2 && i < wr_a.size(); i++) begin
      vectors++; if (wr_a[i] !== 19'(ea[i])) begin miscompares++; $display("FAIL t3_addr[%0d]: got %0d required %0d", i, wr_a[i], ea[i]); end
      vectors++; if (wr_w[i] !== ew[i]) begin miscompares++; $display("FAIL t3_wea[%0d]: got %b required %b", i, wr_w[i], ew[i]); end
    end
    vectors++; if (done_t != acc + 35) begin miscompares++; $display("FAIL t3_done_time: got %0t required %0t", done_t, acc + 35); end
  endtask

  task automatic test_empty;
    int xs[4]; int ys[4]; int ws[4]; int hs[4];
    time acc; int d0;
    xs = '{10, 700, 0, 5}; ys = '{10, 5, 480, 5}; ws = '{0, 4, 4, 4}; hs = '{3, 3, 3, 0};
    for (int k = 0; k < 4; k++) begin
      clear_log(); d0 = done_cnt;
      @(negedge clk); drive_cmd(xs[k], ys[k], ws[k], hs[k], 8'hFF);
      wait_accept(1'b0, acc);
      wait_done(d0);
      vectors++; if (wr_a.size() != 0) begin miscompares++; $display("FAIL t4_writes[%0d]: got %0d required 0", k, wr_a.size()); end
      vectors++; if (done_t != acc + 15) begin miscompares++; $display("FAIL t4_done_time[%0d]: got %0t required %0t", k, done_t, acc + 15); end
    end
  endtask

  task automatic test_back_to_back;
    time acc_a, acc_b, td_a; int d0; int ea;
    clear_log(); d0 = done_cnt;
    @(negedge clk); drive_cmd(0, 10, 16, 2, 8'h55);
    wait_accept(1'b1, acc_a);
    @(negedge clk); drive_cmd(5, 0, 1, 1, 8'hAA);
    repeat (4) @(negedge clk);
    vectors++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL t5_busy_ready: ready %b busy %b required 0 1", bus.cmd_ready, bus.busy); end
    wait_done(d0);
    td_a = done_t;
    wait_accept(1'b0, acc_b);
    wait_done(d0 + 1);
    vectors++; if (acc_b != td_a + 15) begin miscompares++; $display("FAIL t5_accept_b: got %0t required %0t", acc_b, td_a + 15); end
    vectors++; if (wr_a.size() != 9) begin miscompares++; $display("FAIL t5_count: got %0d required 9", wr_a.size()); end
    for (int i = 0; i < 8 && i < wr_a.size(); i++) begin
      ea = 6400 + 640 * (i / 4) + 4 * (i % 4);
      vectors++; if (wr_a[i] !== 19'(ea) || wr_w[i] !== 4'hF || wr_d[i] !== 32'h55555555) begin
        miscompares++; $display("FAIL t5_a[%0d]: got %0d/%b/%h required %0d/1111/55555555", i, wr_a[i], wr_w[i], wr_d[i], ea);
      end
    end
    if (wr_a.size() == 9) begin
      vectors++; if (wr_a[8] !== 19'd5 || wr_w[8] !== 4'b0010 || wr_d[8] !== 32'hAAAAAAAA) begin
        miscompares++; $display("FAIL t5_b: got %0d/%b/%h required 5/0010/aaaaaaaa", wr_a[8], wr_w[8], wr_d[8]);
      end
      vectors++; if (wr_t[8] != acc_b + 15) begin miscompares++; $display("FAIL t5_b_time: got %0t required %0t", wr_t[8], acc_b + 15); end
    end
  endtask

  task automatic test_reset_mid_fill;
    time acc; int d0; int n;
    int ea[2]; logic [3:0] ew[2];
    ea = '{1281, 1282}; ew = '{4'b0010, 4'b0100};
    clear_log(); d0 = done_cnt;
    @(negedge clk); drive_cmd(0, 0, 64, 64, 8'h7E);
    wait_accept(1'b0, acc);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    vectors++; if (bus.bram_ena !== 1'b0 || bus.bram_wea !== 4'h0) begin miscompares++; $display("FAIL t6_abort_port: ena %b wea %b required 0 0", bus.bram_ena, bus.bram_wea); end
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL t6_abort_status: busy %b done %b required 0 0", bus.busy, bus.done); end
    n = wr_a.size();
    vectors++; if (n != 5) begin miscompares++; $display("FAIL t6_pre_count: got %0d required 5", n); end
    for (int i = 0; i < n; i++) begin
      vectors++; if (wr_a[i] !== 19'(4 * i) || wr_w[i] !== 4'hF) begin miscompares++; $display("FAIL t6_pre[%0d]: got %0d/%b required %0d/1111", i, wr_a[i], wr_w[i], 4 * i); end
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (wr_a.size() != n || done_cnt != d0) begin miscompares++; $display("FAIL t6_quiet: writes %0d dones %0d required %0d %0d", wr_a.size(), done_cnt, n, d0); end
    clear_log();
    drive_cmd(1, 2, 2, 1, 8'h92);
    wait_accept(1'b0, acc);
    wait_done(d0);
    vectors++; if (wr_a.size() != 2) begin miscompares++; $display("FAIL t6_count: got %0d required 2", wr_a.size()); end
    for (int i = 0; i < 2 && i < wr_a.size(); i++) begin
      vectors++; if (wr_a[i] !== 19'(ea[i]) || wr_w[i] !== ew[i] || wr_d[i] !== 32'h92929292) begin
        miscompares++; $display("FAIL t6_post[%0d]: got %0d/%b/%h required %0d/%b/92929292", i, wr_a[i], wr_w[i], wr_d[i], ea[i], ew[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_fill();
    test_partial_row();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid_fill();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
